alu_arb: RTL and testbench

ALU_ARB -- requirements
Module: alu_arb

---
 rtl/alu_arb_pkg.sv | 33 +++
 rtl/alu_arb_rr_arb2.sv | 77 +++++++
 rtl/alu_arb.sv | 136 +++++++++++++
 tb/tb_alu_arb.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// ----------------------------------------------------------------------------
// alu_arb_pkg
// Shared types and constants for the two-port ALU arbiter.
//   state_e      : IDLE -> EXEC -> RESP sequencer states
//   FUN_*        : ALUFun codes understood by the shared combinational ALU
//   port_onehot  : converts a 1-bit port index into a 2-bit one-hot mask
// Optional feature macro used by files importing this package: ALU_ARB_LOCK_EN
// ----------------------------------------------------------------------------
package alu_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [5:0] FUN_ADD = 6'b000000;
  localparam logic [5:0] FUN_SUB = 6'b000001;
  localparam logic [5:0] FUN_AND = 6'b011000;
  localparam logic [5:0] FUN_OR  = 6'b011110;
  localparam logic [5:0] FUN_XOR = 6'b010110;
  localparam logic [5:0] FUN_NOR = 6'b010001;
  localparam logic [5:0] FUN_SLL = 6'b100000;
  localparam logic [5:0] FUN_SRL = 6'b100001;
  localparam logic [5:0] FUN_SRA = 6'b100011;
  localparam logic [5:0] FUN_EQ  = 6'b110011;
  localparam logic [5:0] FUN_LT  = 6'b110101;

  function automatic logic [1:0] port_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu_arb_rr_arb2.sv
// ----------------------------------------------------------------------------
// rr_arb2
// Two-requester grant logic with a round-robin pointer.
//   FAIR_RR=1 : on contention the pointer port wins; pointer moves to the
//               port that was not granted after every accept.
//   FAIR_RR=0 : on contention port 0 wins.
//   A lone requester always wins.
// With ALU_ARB_LOCK_EN defined, a lock on an accepted request makes the same
// port win the next contention and leaves the pointer where it was.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   i_req[1:0]       requests eligible for arbitration this cycle
//   i_accept         the current grant is being accepted at this edge
//   i_lock           lock flag of the accepted request (ALU_ARB_LOCK_EN only)
//   o_grant_valid    at least one eligible request
//   o_grant_idx      winning port index
// ----------------------------------------------------------------------------
module rr_arb2 #(
  parameter int FAIR_RR = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_accept,
`ifdef ALU_ARB_LOCK_EN
  input  logic       i_lock,
`endif
  output logic       o_grant_valid,
  output logic       o_grant_idx
);

  logic r_ptr;
  logic w_pref;
`ifdef ALU_ARB_LOCK_EN
  logic r_lock_valid;
  logic r_lock_idx;
`endif

  // NOTE: every output of a combinational block is given a default first so
  // no path through the block leaves a value unassigned (no latch inferred).
  always_comb begin
    w_pref        = (FAIR_RR != 0) ? r_ptr : 1'b0;
`ifdef ALU_ARB_LOCK_EN
    if (r_lock_valid) w_pref = r_lock_idx;
`endif
    o_grant_valid = |i_req;
    o_grant_idx   = 1'b0;
    case (i_req)
      2'b01:   o_grant_idx = 1'b0;
      2'b10:   o_grant_idx = 1'b1;
      2'b11:   o_grant_idx = w_pref;
      default: o_grant_idx = 1'b0;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr        <= 1'b0;
`ifdef ALU_ARB_LOCK_EN
      r_lock_valid <= 1'b0;
      r_lock_idx   <= 1'b0;
`endif
    end else if (i_accept) begin
`ifdef ALU_ARB_LOCK_EN
      // A lock lasts for exactly one following arbitration.
      r_lock_valid <= i_lock;
      if (i_lock) r_lock_idx <= o_grant_idx;
      else        r_ptr      <= ~o_grant_idx;
`else
      r_ptr <= ~o_grant_idx;
`endif
    end
  end

endmodule

// File: rtl/alu_arb.sv
// ----------------------------------------------------------------------------
// alu_arb
// Shares one external combinational ALU between two request/response ports.
// Each operation runs IDLE (accept) -> EXEC (ALU driven, result captured)
// -> RESP (result held until the granted port takes it) -> IDLE.
// Parameter:
//   FAIR_RR   1 = round-robin between ports, 0 = fixed priority (port 0)
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready[1:0]   per-port request handshake
//   req_a/req_b[63:0]          per-port operands, port p at [p*32 +: 32]
//   req_fun[11:0]              per-port ALUFun, port p at [p*6 +: 6]
//   req_sign[1:0]              per-port signed flag
//   req_lock[1:0]              per-port lock (only with ALU_ARB_LOCK_EN)
//   alu_a/alu_b/alu_fun/alu_sign  operands to the shared ALU
//   alu_s                      ALU result
//   rsp_valid/rsp_ready[1:0]   per-port response handshake
//   rsp_data                   result, shared by both ports
// Optional feature macro: ALU_ARB_LOCK_EN
// ----------------------------------------------------------------------------
module alu_arb
  import alu_arb_pkg::*;
#(
  parameter int FAIR_RR = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [63:0] req_a,
  input  logic [63:0] req_b,
  input  logic [11:0] req_fun,
  input  logic [1:0]  req_sign,
`ifdef ALU_ARB_LOCK_EN
  input  logic [1:0]  req_lock,
`endif
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [5:0]  alu_fun,
  output logic        alu_sign,
  input  logic [31:0] alu_s,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [31:0] rsp_data
);

  state_e      r_state;
  state_e      w_state_next;
  logic        r_grant;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [5:0]  r_fun;
  logic        r_sign;
  logic [31:0] r_rsp_data;

  logic [1:0]  w_arb_req;
  logic        w_grant_valid;
  logic        w_grant_idx;
  logic        w_accept;

  // Only IDLE arbitrates; requests in EXEC/RESP are invisible to the arbiter.
  assign w_arb_req = (r_state == ST_IDLE) ? req_valid : 2'b00;
  // The granted port always has req_valid set, so a grant in IDLE is an accept.
  assign w_accept  = w_grant_valid;

  rr_arb2 #(
    .FAIR_RR (FAIR_RR)
  ) u_arb (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_req         (w_arb_req),
    .i_accept      (w_accept),
`ifdef ALU_ARB_LOCK_EN
    .i_lock        (req_lock[w_grant_idx]),
`endif
    .o_grant_valid (w_grant_valid),
    .o_grant_idx   (w_grant_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    req_ready    = 2'b00;
    rsp_valid    = 2'b00;
    case (r_state)
      ST_IDLE: begin
        // rst_n gating keeps req_ready low for the whole reset pulse.
        if (rst_n && w_grant_valid) begin
          req_ready    = port_onehot(w_grant_idx);
          w_state_next = ST_EXEC;
        end
      end
      ST_EXEC: w_state_next = ST_RESP;
      ST_RESP: begin
        rsp_valid = port_onehot(r_grant);
        // Only the granted port's rsp_ready completes the response.
        if (rsp_ready[r_grant]) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // NOTE: the datapath registers are reset as well, because alu_* and
  // rsp_data must read zero while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant    <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_fun      <= '0;
      r_sign     <= 1'b0;
      r_rsp_data <= '0;
    end else begin
      if (w_accept) begin
        r_grant <= w_grant_idx;
        r_a     <= w_grant_idx ? req_a[63:32]  : req_a[31:0];
        r_b     <= w_grant_idx ? req_b[63:32]  : req_b[31:0];
        r_fun   <= w_grant_idx ? req_fun[11:6] : req_fun[5:0];
        r_sign  <= req_sign[w_grant_idx];
      end
      if (r_state == ST_EXEC) r_rsp_data <= alu_s;
    end
  end

  // ALU inputs simply hold the last accepted operation outside EXEC.
  assign alu_a    = r_a;
  assign alu_b    = r_b;
  assign alu_fun  = r_fun;
  assign alu_sign = r_sign;
  assign rsp_data = r_rsp_data;

endmodule

// File: tb/tb_alu_arb.sv
// ----------------------------------------------------------------------------
// tb_alu_arb
// Two DUT instances: u_rr (FAIR_RR=1) with a scoreboard/monitor, and u_fp
// (FAIR_RR=0) for fixed-priority behaviour. The shared ALU is modelled here.
// Lock scenario is compiled in only with ALU_ARB_LOCK_EN.
// ----------------------------------------------------------------------------
module tb_alu_arb;
  import alu_arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Round-robin instance signals
  logic [1:0]  req_valid, req_ready, req_sign, rsp_valid, rsp_ready;
  logic [63:0] req_a, req_b;
  logic [11:0] req_fun;
  logic [31:0] alu_a, alu_b, alu_s, rsp_data;
  logic [5:0]  alu_fun;
  logic        alu_sign;
  // Fixed-priority instance signals
  logic [1:0]  req_valid_fp, req_ready_fp, req_sign_fp, rsp_valid_fp, rsp_ready_fp;
  logic [63:0] req_a_fp, req_b_fp;
  logic [11:0] req_fun_fp;
  logic [31:0] alu_a_fp, alu_b_fp, alu_s_fp, rsp_data_fp;
  logic [5:0]  alu_fun_fp;
  logic        alu_sign_fp;
`ifdef ALU_ARB_LOCK_EN
  logic [1:0]  req_lock, req_lock_fp;
`endif

  // Behavioural shared ALU
  function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [5:0] fun, input logic sign);
    case (fun)
      FUN_ADD: return a + b;
      FUN_SUB: return a - b;
      FUN_AND: return a & b;
      FUN_OR:  return a | b;
      FUN_XOR: return a ^ b;
      FUN_NOR: return ~(a | b);
      FUN_SLL: return a << b[4:0];
      FUN_SRL: return a >> b[4:0];
      FUN_SRA: return $unsigned($signed(a) >>> b[4:0]);
      FUN_EQ:  return {31'b0, a == b};
      FUN_LT:  return {31'b0, sign ? ($signed(a) < $signed(b)) : (a < b)};
      default: return 32'h0;
    endcase
  endfunction

  assign alu_s    = alu_model(alu_a, alu_b, alu_fun, alu_sign);
  assign alu_s_fp = alu_model(alu_a_fp, alu_b_fp, alu_fun_fp, alu_sign_fp);

  alu_arb #(.FAIR_RR(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_fun(req_fun), .req_sign(req_sign),
`ifdef ALU_ARB_LOCK_EN
    .req_lock(req_lock),
`endif
    .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun), .alu_sign(alu_sign),
    .alu_s(alu_s), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data)
  );

  alu_arb #(.FAIR_RR(0)) u_fp (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_fp), .req_ready(req_ready_fp),
    .req_a(req_a_fp), .req_b(req_b_fp), .req_fun(req_fun_fp), .req_sign(req_sign_fp),
`ifdef ALU_ARB_LOCK_EN
    .req_lock(req_lock_fp),
`endif
    .alu_a(alu_a_fp), .alu_b(alu_b_fp), .alu_fun(alu_fun_fp), .alu_sign(alu_sign_fp),
    .alu_s(alu_s_fp), .rsp_valid(rsp_valid_fp), .rsp_ready(rsp_ready_fp), .rsp_data(rsp_data_fp)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [1:0] oh(input int p);
    return (p == 1) ? 2'b10 : 2'b01;
  endfunction

  // Scoreboard
  typedef struct { int port; logic [31:0] data; } exp_t;
  exp_t        sb_q[$];
  bit          busy = 1'b0;
  bit          held = 1'b0;
  logic [31:0] held_data;
  bit          hold_low = 1'b0;
  bit          rand_ready = 1'b0;

  // Arbitration reference: favoured port, one-shot lock
  int m_ptr = 0;
  bit m_lock_v = 1'b0;
  int m_lock_p = 0;

  // Pending request per port
  bit          pend[2];
  logic [31:0] op_a[2], op_b[2];
  logic [5:0]  op_fun[2];
  bit          op_sign[2], op_lock[2];
  logic [5:0]  funs[11] = '{FUN_ADD, FUN_SUB, FUN_AND, FUN_OR, FUN_XOR, FUN_NOR,
                            FUN_SLL, FUN_SRL, FUN_SRA, FUN_EQ, FUN_LT};

  // Response-side backpressure, changed away from the sampling edge
  always @(posedge clk) begin
    #2;
    if (hold_low)        rsp_ready = 2'b00;
    else if (rand_ready) rsp_ready = 2'($urandom_range(0, 3));
    else                 rsp_ready = 2'b11;
  end

  // Monitor: pops an expectation whenever a response handshake is presented
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && rsp_valid != 2'b00) begin
      if (held) check("rsp_data stable while waiting", rsp_data, held_data);
      if ((rsp_valid & rsp_ready) != 2'b00) begin
        if (sb_q.size() == 0) begin
          check("unexpected response", rsp_valid, 2'b00);
        end else begin
          e = sb_q.pop_front();
          check("rsp port", rsp_valid, oh(e.port));
          check("rsp data", rsp_data, e.data);
        end
        busy = 1'b0;
        held = 1'b0;
      end else begin
        held      = 1'b1;
        held_data = rsp_data;
      end
    end
  end

  task automatic set_req(input int p, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] fun, input bit sign, input bit lock);
    pend[p] = 1'b1; op_a[p] = a; op_b[p] = b; op_fun[p] = fun;
    op_sign[p] = sign; op_lock[p] = lock;
  endtask

  task automatic rand_req(input int p);
    logic [31:0] a, b;
    bit lk;
    a = $urandom;
    b = ($urandom_range(0, 3) == 0) ? a : $urandom;
    lk = 1'b0;
`ifdef ALU_ARB_LOCK_EN
    lk = ($urandom_range(0, 2) == 0);
`endif
    set_req(p, a, b, funs[$urandom_range(0, 10)], 1'($urandom_range(0, 1)), lk);
  endtask

  task automatic drive_reqs(input bit en);
    for (int p = 0; p < 2; p++) begin
      req_valid[p]        = en & pend[p];
      req_a[p*32 +: 32]   = op_a[p];
      req_b[p*32 +: 32]   = op_b[p];
      req_fun[p*6 +: 6]   = op_fun[p];
      req_sign[p]         = op_sign[p];
`ifdef ALU_ARB_LOCK_EN
      req_lock[p]         = op_lock[p];
`endif
    end
  endtask

  function automatic int predict();
    if (pend[0] && pend[1]) return m_lock_v ? m_lock_p : m_ptr;
    return pend[1] ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_lock_v = 1'b0; m_lock_p = 0;
    sb_q.delete(); busy = 1'b0; held = 1'b0;
  endtask

  // One arbitration + operation on u_rr. stall: hold rsp_ready low 3 RESP
  // cycles. rst_mid: pulse reset in EXEC and expect the op to vanish.
  task automatic arbitrate(input bit stall, input bit rst_mid, output int g);
    int exp_g;
    int n;
    logic [31:0] exp_d;
    @(negedge clk);
    drive_reqs(1'b1);
    #1;
    exp_g = predict();
    check("req_ready grant", req_ready, oh(exp_g));
    g = req_ready[1] ? 1 : 0;
    exp_d = alu_model(op_a[exp_g], op_b[exp_g], op_fun[exp_g], op_sign[exp_g]);
    hold_low = stall;
    if (op_lock[exp_g]) begin m_lock_v = 1'b1; m_lock_p = exp_g; end
    else begin m_lock_v = 1'b0; m_ptr = 1 - exp_g; end
    pend[exp_g] = 1'b0;
    if (!rst_mid) begin sb_q.push_back('{exp_g, exp_d}); busy = 1'b1; end
    @(posedge clk);
    if (rst_mid) begin
      #2;
      rst_n = 1'b0;
      #1;
      check("reset req_ready", req_ready, 2'b00);
      check("reset rsp_valid", rsp_valid, 2'b00);
      check("reset rsp_data", rsp_data, 0);
      check("reset alu_a/alu_b", {alu_a, alu_b}, 0);
      check("reset alu_sign/alu_fun", {alu_sign, alu_fun}, 0);
      model_reset();
      @(negedge clk);
      drive_reqs(1'b0);
      rst_n = 1'b1;
      return;
    end
    @(negedge clk);
    drive_reqs(1'b0);
    check("exec alu_a/alu_b", {alu_a, alu_b}, {op_a[exp_g], op_b[exp_g]});
    check("exec alu_sign/alu_fun", {alu_sign, alu_fun}, {op_sign[exp_g], op_fun[exp_g]});
    check("exec rsp_valid low", rsp_valid, 2'b00);
    check("exec req_ready low", req_ready, 2'b00);
    @(negedge clk);
    check("latency rsp_valid", rsp_valid, oh(exp_g));
    if (stall) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        check("stall rsp_valid held", rsp_valid, oh(exp_g));
        check("stall rsp_data", rsp_data, exp_d);
        check("stall req_ready low", req_ready, 2'b00);
      end
      hold_low = 1'b0;
    end
    n = 0;
    while (busy && n < 40) begin @(negedge clk); n++; end
    if (busy) begin
      check("response timeout", 1, 0);
      model_reset();
    end
  endtask

  task automatic fp_test();
    int n;
    logic [31:0] exp_d;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      req_a_fp     = {$urandom, $urandom};
      req_b_fp     = {$urandom, $urandom};
      req_fun_fp   = {funs[$urandom_range(0, 10)], funs[$urandom_range(0, 10)]};
      req_sign_fp  = 2'($urandom_range(0, 3));
      req_valid_fp = 2'b11;
      #1;
      n = 0;
      while (req_ready_fp == 2'b00 && n < 20) begin @(negedge clk); #1; n++; end
      check("fixed-priority grant", req_ready_fp, 2'b01);
      exp_d = alu_model(req_a_fp[31:0], req_b_fp[31:0], req_fun_fp[5:0], req_sign_fp[0]);
      n = 0;
      do begin @(negedge clk); n++; end while (rsp_valid_fp == 2'b00 && n < 20);
      check("fixed-priority rsp_valid", rsp_valid_fp, 2'b01);
      check("fixed-priority rsp_data", rsp_data_fp, exp_d);
    end
    req_valid_fp = 2'b00;
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int g;
    req_valid = 2'b00; req_a = '0; req_b = '0; req_fun = '0; req_sign = '0;
    rsp_ready = 2'b11;
    req_valid_fp = 2'b00; req_a_fp = '0; req_b_fp = '0; req_fun_fp = '0;
    req_sign_fp = '0; rsp_ready_fp = 2'b11;
`ifdef ALU_ARB_LOCK_EN
    req_lock = 2'b00; req_lock_fp = 2'b00;
`endif
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0; op_a[p] = '0; op_b[p] = '0; op_fun[p] = '0;
      op_sign[p] = 1'b0; op_lock[p] = 1'b0;
    end

    // Reset state, with requests present to show req_ready stays low
    req_valid = 2'b11;
    #2;
    check("por req_ready", req_ready, 2'b00);
    check("por rsp_valid", rsp_valid, 2'b00);
    check("por rsp_data", rsp_data, 0);
    check("por alu_a/alu_b", {alu_a, alu_b}, 0);
    check("por alu_sign/alu_fun", {alu_sign, alu_fun}, 0);
    req_valid = 2'b00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Contention with pointer at port 0: SUB 10-3 then OR F0|0F
    set_req(0, 32'd10, 32'd3, FUN_SUB, 1'b0, 1'b0);
    set_req(1, 32'h0000_00F0, 32'h0000_000F, FUN_OR, 1'b0, 1'b0);
    arbitrate(1'b0, 1'b0, g);
    check("contention first grant port", g, 0);
    arbitrate(1'b0, 1'b0, g);
    check("contention second grant port", g, 1);

    // Lone port 0 ADD 5+7
    set_req(0, 32'd5, 32'd7, FUN_ADD, 1'b0, 1'b0);
    arbitrate(1'b0, 1'b0, g);

    // Port 1 signed LT -1 < 1 with rsp_ready held low 3 cycles
    set_req(1, 32'hFFFF_FFFF, 32'd1, FUN_LT, 1'b1, 1'b0);
    arbitrate(1'b1, 1'b0, g);

    // Reset during EXEC discards the operation
    set_req(0, 32'h1234_5678, 32'h0F0F_0F0F, FUN_XOR, 1'b0, 1'b0);
    arbitrate(1'b0, 1'b1, g);
    repeat (3) @(negedge clk);
    check("no response after reset", rsp_valid, 2'b00);
    set_req(1, 32'd100, 32'd23, FUN_ADD, 1'b0, 1'b0);
    arbitrate(1'b0, 1'b0, g);
    check("post-reset grant port", g, 1);

    // Randomized traffic with random backpressure
    rand_ready = 1'b1;
    for (int r = 0; r < 40; r++) begin
      for (int p = 0; p < 2; p++)
        if (!pend[p] && $urandom_range(0, 1) == 1) rand_req(p);
      if (!pend[0] && !pend[1]) rand_req(int'($urandom_range(0, 1)));
      arbitrate(1'b0, 1'b0, g);
    end
    while (pend[0] || pend[1]) arbitrate(1'b0, 1'b0, g);
    rand_ready = 1'b0;

    fp_test();

`ifdef ALU_ARB_LOCK_EN
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    set_req(0, 32'd1, 32'd2, FUN_ADD, 1'b0, 1'b1);
    set_req(1, 32'd9, 32'd4, FUN_SUB, 1'b0, 1'b0);
    arbitrate(1'b0, 1'b0, g);
    check("lock grant 1", g, 0);
    set_req(0, 32'd3, 32'd4, FUN_ADD, 1'b0, 1'b1);
    arbitrate(1'b0, 1'b0, g);
    check("lock grant 2", g, 0);
    set_req(0, 32'd5, 32'd6, FUN_ADD, 1'b0, 1'b0);
    arbitrate(1'b0, 1'b0, g);
    check("lock grant 3", g, 0);
    arbitrate(1'b0, 1'b0, g);
    check("lock grant 4", g, 1);
`endif

    repeat (3) @(negedge clk);
    check("scoreboard drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
